seed_match_stage: RTL and testbench

//   Consumer stage directly downstream of the 2-bit-per-base database shift register.

---
 rtl/blast_pkg.sv | 21 ++
 rtl/hit_fifo.sv | 59 +++++
 rtl/seed_match_stage.sv | 107 ++++++++++
 tb/tb_seed_match_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blast_pkg.sv
// Shared definitions for the seed-match datapath.
//   BASE_W    : bits per nucleotide base
//   base_t    : 2-bit base codes (A/C/G/T)
//   hit_t     : hit record carrying the database position of a match
package blast_pkg;

  localparam int unsigned BASE_W    = 2;
  localparam int unsigned HIT_POS_W = 32;

  typedef enum logic [BASE_W-1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } base_t;

  typedef struct packed {
    logic [HIT_POS_W-1:0] pos;
  } hit_t;

endpackage

// File: rtl/hit_fifo.sv
// Synchronous FIFO with pointer + occupancy counter.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, wdata     : write request / data (ignored when full unless popping)
//   pop             : read request (ignored when empty)
//   rdata           : head entry
//   full, empty     : occupancy flags
//   count           : current number of entries
module hit_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push on full is still accepted.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seed_match_stage.sv
// Seed-match consumer stage behind the 2-bit/base database shift register.
//   clk, rst           : clock, asynchronous active-low reset
//   queryLoad, queryIn : load query seed (base 0 in bits [1:0])
//   windowData         : lowest SEED_LEN bases of the shifter output
//   windowValid        : shifter advanced, new window present
//   windowStart        : with windowValid, first window of a new sequence
//   stall              : upstream must not shift while high
//   hitValid/hitReady  : hit FIFO drain handshake
//   hitPos             : database position of the head hit
//   hitCount           : saturating count of accepted hits
//   overflow           : sticky, a hit was dropped on a full FIFO
module seed_match_stage
  import blast_pkg::*;
#(
  parameter int unsigned SEED_LEN   = 11,
  parameter int unsigned POS_W      = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       queryLoad,
  input  logic [BASE_W*SEED_LEN-1:0] queryIn,
  input  logic [BASE_W*SEED_LEN-1:0] windowData,
  input  logic                       windowValid,
  input  logic                       windowStart,
  output logic                       stall,
  output logic                       hitValid,
  input  logic                       hitReady,
  output logic [POS_W-1:0]           hitPos,
  output logic [15:0]                hitCount,
  output logic                       overflow
);

  localparam int unsigned WIN_W = BASE_W * SEED_LEN;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  // Headroom of 3: two compare stages in flight plus one cycle of stall latency.
  localparam logic [CW-1:0] STALL_AT = CW'(FIFO_DEPTH - 3);

  logic [WIN_W-1:0] query;
  logic [POS_W-1:0] db_pos;
  logic [POS_W-1:0] win_pos;

  logic             s1_valid;
  logic [WIN_W-1:0] s1_win;
  logic [POS_W-1:0] s1_pos;
  logic             s2_match;
  logic [POS_W-1:0] s2_pos;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             pop;
  logic             push_ok;

  assign win_pos  = windowStart ? '0 : db_pos;
  assign hitValid = ~fifo_empty;
  assign pop      = hitValid & hitReady;
  assign push_ok  = s2_match & (~fifo_full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      query    <= '0;
      db_pos   <= '0;
      s1_valid <= 1'b0;
      s1_win   <= '0;
      s1_pos   <= '0;
      s2_match <= 1'b0;
      s2_pos   <= '0;
      stall    <= 1'b0;
      hitCount <= '0;
      overflow <= 1'b0;
    end else begin
      if (queryLoad) query <= queryIn;

      // Position keeps advancing even when queryLoad discards the window.
      if (windowValid) db_pos <= win_pos + 1'b1;

      s1_valid <= windowValid & ~queryLoad;
      s1_win   <= windowData;
      s1_pos   <= win_pos;

      s2_match <= s1_valid & ~queryLoad & (s1_win == query);
      s2_pos   <= s1_pos;

      stall <= (fifo_count >= STALL_AT);

      if (push_ok && (hitCount != '1)) hitCount <= hitCount + 1'b1;
      if (s2_match && !push_ok)        overflow <= 1'b1;
    end
  end

  hit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (POS_W)
  ) u_hit_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (s2_match),
    .wdata (s2_pos),
    .pop   (pop),
    .rdata (hitPos),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_seed_match_stage.sv
module tb_seed_match_stage;

  logic        clk;
  logic        rst;
  logic        queryLoad;
  logic [21:0] queryIn;
  logic [21:0] windowData;
  logic        windowValid;
  logic        windowStart;
  logic        stall;
  logic        hitValid;
  logic        hitReady;
  logic [31:0] hitPos;
  logic [15:0] hitCount;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int sent;
  logic [21:0] Q;

  seed_match_stage #(
    .SEED_LEN   (11),
    .POS_W      (32),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .queryLoad   (queryLoad),
    .queryIn     (queryIn),
    .windowData  (windowData),
    .windowValid (windowValid),
    .windowStart (windowStart),
    .stall       (stall),
    .hitValid    (hitValid),
    .hitReady    (hitReady),
    .hitPos      (hitPos),
    .hitCount    (hitCount),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] seq(input string s);
    logic [21:0] v;
    logic [1:0]  code;
    v = '0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "A":     code = 2'b00;
        "C":     code = 2'b01;
        "G":     code = 2'b10;
        default: code = 2'b11;
      endcase
      v[2*i +: 2] = code;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic s, input logic [21:0] d);
    windowValid = v;
    windowStart = s;
    windowData  = d;
  endtask

  task automatic reset_dut();
    drv(1'b0, 1'b0, '0);
    hitReady  = 1'b0;
    queryLoad = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic load_q();
    queryIn   = Q;
    queryLoad = 1'b1;
    tick();
    queryLoad = 1'b0;
  endtask

  initial begin
    Q = seq("ACGTACGTACG");
    rst = 1'b0; queryLoad = 1'b0; queryIn = '0; hitReady = 1'b0;
    drv(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("rst_hitValid", hitValid, 0);
    chk("rst_stall",    stall,    0);
    chk("rst_hitCount", hitCount, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_hitPos",   hitPos,   0);
    rst = 1'b1;
    tick();

    // 1: single exact match at window 5, visible 3 cycles after acceptance
    load_q();
    for (int k = 0; k < 20; k++) begin
      drv(1'b1, k == 0, (k == 5) ? Q : (Q ^ 22'(k + 1)));
      tick();
      chk("t1_hitValid_timing", hitValid, (k >= 7));
    end
    drv(1'b0, 1'b0, '0);
    chk("t1_hitPos",   hitPos,   5);
    chk("t1_hitCount", hitCount, 1);
    chk("t1_overflow", overflow, 0);
    hitReady = 1'b1; tick(); hitReady = 1'b0;
    chk("t1_drained", hitValid, 0);

    // 2: match every window, upstream obeys stall
    reset_dut();
    load_q();
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      if (!stall) begin
        drv(1'b1, sent == 0, Q);
        sent++;
      end else drv(1'b0, 1'b0, '0);
      tick();
      chk("t2_overflow", overflow, 0);
    end
    drv(1'b0, 1'b0, '0);
    chk("t2_sent",     sent,     8);
    chk("t2_stall",    stall,    1);
    chk("t2_hitCount", hitCount, 8);
    hitReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_valid", hitValid, 1);
      chk("t2_drain_pos",   hitPos,   i);
      tick();
    end
    hitReady = 1'b0;
    chk("t2_empty",     hitValid, 0);
    chk("t2_stall_low", stall,    0);

    // 3: upstream ignores stall, 9th hit dropped
    reset_dut();
    load_q();
    for (int k = 0; k < 9; k++) begin
      drv(1'b1, k == 0, Q);
      tick();
    end
    drv(1'b0, 1'b0, '0);
    tick(); tick(); tick();
    chk("t3_overflow", overflow, 1);
    chk("t3_hitCount", hitCount, 8);
    chk("t3_stall",    stall,    1);
    hitReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain_pos", hitPos, i);
      tick();
    end
    hitReady = 1'b0;
    chk("t3_empty",           hitValid, 0);
    chk("t3_overflow_sticky", overflow, 1);

    // 5: full FIFO with simultaneous push and pop
    reset_dut();
    load_q();
    for (int k = 0; k < 8; k++) begin
      drv(1'b1, k == 0, Q);
      tick();
    end
    drv(1'b0, 1'b0, '0);
    tick(); tick(); tick();
    chk("t5_full_valid", hitValid, 1);
    chk("t5_full_stall", stall,    1);
    drv(1'b1, 1'b0, Q); tick();
    drv(1'b1, 1'b0, Q); tick();
    hitReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drv(i < 6, 1'b0, Q);
      chk("t5_valid", hitValid, 1);
      chk("t5_pos",   hitPos,   i);
      tick();
    end
    hitReady = 1'b0;
    drv(1'b0, 1'b0, '0);
    chk("t5_empty",    hitValid, 0);
    chk("t5_overflow", overflow, 0);
    chk("t5_hitCount", hitCount, 16);

    // 4: windowStart restarts position numbering
    reset_dut();
    load_q();
    for (int k = 0; k < 100; k++) begin
      drv(1'b1, k == 0, Q ^ 22'(k + 1));
      tick();
    end
    drv(1'b1, 1'b1, Q);        tick();
    drv(1'b1, 1'b0, Q ^ 22'd1); tick();
    drv(1'b1, 1'b0, Q ^ 22'd2); tick();
    drv(1'b1, 1'b0, Q);        tick();
    drv(1'b0, 1'b0, '0);
    tick(); tick(); tick();
    chk("t4_valid", hitValid, 1);
    chk("t4_pos0",  hitPos,   0);
    hitReady = 1'b1; tick(); hitReady = 1'b0;
    chk("t4_pos3",     hitPos,   3);
    chk("t4_hitCount", hitCount, 2);

    // 6: asynchronous reset mid-stream, then queryLoad discarding in-flight windows
    reset_dut();
    load_q();
    for (int k = 0; k < 6; k++) begin
      drv(1'b1, k == 0, Q);
      tick();
    end
    drv(1'b0, 1'b0, '0);
    chk("t6_pre_valid", hitValid, 1);
    chk("t6_pre_count", hitCount, 4);
    rst = 1'b0;
    #1;
    chk("t6_rst_hitValid", hitValid, 0);
    chk("t6_rst_stall",    stall,    0);
    chk("t6_rst_hitCount", hitCount, 0);
    chk("t6_rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(); tick(); tick();
    chk("t6_inflight_cleared", hitValid, 0);

    load_q();
    drv(1'b1, 1'b1, Q); tick();
    queryLoad = 1'b1;
    drv(1'b1, 1'b0, Q); tick();
    queryLoad = 1'b0;
    drv(1'b1, 1'b0, Q); tick();
    drv(1'b0, 1'b0, '0);
    tick(); tick(); tick();
    chk("t6_ql_valid", hitValid, 1);
    chk("t6_ql_pos",   hitPos,   2);
    chk("t6_ql_count", hitCount, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
